parity_share_arbiter: RTL and testbench

Round-robin scheduler that shares a single registered parity unit among `NUM_REQ` requesters. Each requester presents a `DATA_W`-bit word. The block picks one requester, latches its word and computes its parity (XOR of all bits: 1 = odd number of ones). It then returns the result with the requester's index over a valid/ready response port. The block sits between parity producers (frame builders, checkers) and the shared parity datapath, and keeps a saturating count of odd results.

---
 rtl/parity_pkg.sv | 29 ++
 rtl/parity_share_arbiter_rr_pick.sv | 37 +++
 rtl/parity_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_parity_share_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the round-robin parity arbiter.
//   state_e     : arbiter FSM states
//   ODD_CNT_W   : width of the saturating odd-result counter
//   ODD_CNT_MAX : saturation value of that counter
//   clog2()     : index width helper (returns at least 1)
package parity_pkg;

    localparam int unsigned ODD_CNT_W = 8;
    localparam logic [ODD_CNT_W-1:0] ODD_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_e;

    // Smallest r with 2**r >= n, never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/parity_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ.
//   en       : in  enable; no winner reported when low
//   req      : in  request vector
//   ptr      : in  highest-priority index
//   valid_c  : out a winner exists
//   winner_c : out winner index
module rr_pick
    import parity_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid_c,
    output logic [ID_W-1:0]    winner_c
);

    logic [ID_W-1:0] idx;

    // Scan from ptr upward; the first hit wins.
    always_comb begin
        valid_c  = 1'b0;
        winner_c = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (en && !valid_c && req[idx]) begin
                valid_c  = 1'b1;
                winner_c = idx;
            end
        end
    end

endmodule

// File: rtl/parity_share_arbiter.sv
// Round-robin scheduler sharing one registered parity unit among NUM_REQ
// requesters, with a valid/ready response port and a saturating odd count.
//   clk, rst   : clock, synchronous active-high reset
//   req        : in  per-requester request level
//   req_data   : in  requester i word at [i*DATA_W +: DATA_W]
//   gnt        : out one-hot pulse while the captured word is computed
//   rsp_valid  : out result available
//   rsp_ready  : in  consumer accepts result
//   rsp_id     : out requester index of the result
//   rsp_parity : out XOR of the captured word
//   busy       : out FSM not idle
//   odd_count  : out saturating count of accepted odd results
module parity_share_arbiter
    import parity_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 3,
    parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_parity,
    output logic                      busy,
    output logic [ODD_CNT_W-1:0]      odd_count
);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [DATA_W-1:0]     op_q, op_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic                  rsp_parity_q, rsp_parity_d;
    logic                  busy_q, busy_d;
    logic [ODD_CNT_W-1:0]  odd_count_q, odd_count_d;

    logic                  pick_en_c;
    logic                  pick_valid_c;
    logic [ID_W-1:0]       pick_id_c;

    assign pick_en_c = (state_q == IDLE);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .en       (pick_en_c),
        .req      (req),
        .ptr      (ptr_q),
        .valid_c  (pick_valid_c),
        .winner_c (pick_id_c)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        op_d         = op_q;
        id_d         = id_q;
        gnt_d        = '0;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_parity_d = rsp_parity_q;
        odd_count_d  = odd_count_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (ID_W'(i) == pick_id_c) begin
                            op_d = req_data[i*DATA_W +: DATA_W];
                        end
                    end
                    id_d    = pick_id_c;
                    ptr_d   = (32'(pick_id_c) == NUM_REQ - 1) ? '0 : pick_id_c + ID_W'(1);
                    // Registered here so gnt is high during the COMPUTE cycle.
                    gnt_d   = NUM_REQ'(1) << pick_id_c;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                rsp_parity_d = ^op_q;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_parity_q && (odd_count_q != ODD_CNT_MAX)) begin
                        odd_count_d = odd_count_q + ODD_CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            op_q         <= '0;
            id_q         <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_parity_q <= 1'b0;
            busy_q       <= 1'b0;
            odd_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            op_q         <= op_d;
            id_q         <= id_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_parity_q <= rsp_parity_d;
            busy_q       <= busy_d;
            odd_count_q  <= odd_count_d;
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_parity = rsp_parity_q;
    assign busy       = busy_q;
    assign odd_count  = odd_count_q;

endmodule

// File: tb/tb_parity_share_arbiter.sv
// Directed bench for parity_share_arbiter with a response scoreboard.
module tb_parity_share_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 3;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned RD_W    = NUM_REQ * DATA_W;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_REQ-1:0] req;
    logic [RD_W-1:0]    req_data;
    logic [NUM_REQ-1:0] gnt;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_parity;
    logic               busy;
    logic [7:0]         odd_count;

    typedef struct {
        int   id;
        logic par;
    } exp_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   exp_odd = 0;

    parity_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_parity (rsp_parity),
        .busy       (busy),
        .odd_count  (odd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Parity by counting ones.
    function automatic logic model_par(input logic [DATA_W-1:0] w);
        int n;
        n = 0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (w[i]) n++;
        end
        return (n % 2) == 1;
    endfunction

    task automatic drive_word(input int i, input logic [DATA_W-1:0] w);
        req_data[i*DATA_W +: DATA_W] = w;
    endtask

    task automatic push_exp(input int id, input logic [DATA_W-1:0] w);
        exp_t e;
        e.id  = id;
        e.par = model_par(w);
        sb.push_back(e);
    endtask

    // Runs one transaction from an IDLE cycle whose request is already driven.
    task automatic run_txn(input int stall);
        exp_t               e;
        logic [NUM_REQ-1:0] hold_req;
        logic [RD_W-1:0]    hold_data;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow observed=0 expected=1");
            return;
        end
        e = sb[0];
        step();
        check("gnt_compute", 32'(gnt), 32'(1) << e.id);
        check("busy_compute", 32'(busy), 1);
        check("valid_compute", 32'(rsp_valid), 0);
        req[e.id] = 1'b0;
        rsp_ready = (stall == 0);
        step();
        check("valid_resp", 32'(rsp_valid), 1);
        check("gnt_resp", 32'(gnt), 0);
        hold_req  = req;
        hold_data = req_data;
        for (int s = 0; s < stall; s++) begin
            req      = NUM_REQ'($urandom);
            req_data = RD_W'($urandom);
            step();
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_id", 32'(rsp_id), 32'(e.id));
            check("bp_par", 32'(rsp_parity), 32'(e.par));
            check("bp_gnt", 32'(gnt), 0);
            check("bp_busy", 32'(busy), 1);
        end
        req       = hold_req;
        req_data  = hold_data;
        rsp_ready = 1'b1;
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_parity", 32'(rsp_parity), 32'(e.par));
        step();
        if (e.par && exp_odd < 255) exp_odd++;
        check("valid_after", 32'(rsp_valid), 0);
        check("busy_after", 32'(busy), 0);
        check("odd_count", 32'(odd_count), 32'(exp_odd));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        exp_odd = 0;
    endtask

    initial begin
        // Reset with random inputs.
        rst       = 1'b1;
        req       = NUM_REQ'($urandom);
        req_data  = RD_W'($urandom);
        rsp_ready = 1'($urandom);
        step();
        step();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_id", 32'(rsp_id), 0);
        check("rst_par", 32'(rsp_parity), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_odd", 32'(odd_count), 0);
        rst = 1'b0;
        req = '0;
        step();
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_valid", 32'(rsp_valid), 0);
        step();
        step();
        check("idle_gnt", 32'(gnt), 0);
        check("idle_busy", 32'(busy), 0);

        // Single request from requester 1, word 011.
        req_data  = '0;
        drive_word(1, 3'b011);
        req       = 4'b0010;
        rsp_ready = 1'b1;
        push_exp(1, 3'b011);
        run_txn(0);

        // All four held high from ptr = 0.
        pulse_reset();
        drive_word(0, 3'b000);
        drive_word(1, 3'b001);
        drive_word(2, 3'b010);
        drive_word(3, 3'b111);
        req = 4'b1111;
        push_exp(0, 3'b000);
        push_exp(1, 3'b001);
        push_exp(2, 3'b010);
        push_exp(3, 3'b111);
        for (int k = 0; k < 4; k++) run_txn(0);
        check("odd_after_four", 32'(odd_count), 3);

        // Backpressure for 5 cycles.
        drive_word(2, 3'b111);
        req = 4'b0100;
        push_exp(2, 3'b111);
        run_txn(5);

        // Reset during COMPUTE with requester 3 pending.
        pulse_reset();
        drive_word(3, 3'b100);
        drive_word(0, 3'b110);
        req = 4'b1000;
        step();
        check("rst_mid_gnt", 32'(gnt), 32'(4'b1000));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_valid", 32'(rsp_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_gnt_clr", 32'(gnt), 0);
        exp_odd = 0;
        req = 4'b1001;
        push_exp(0, 3'b110);
        push_exp(3, 3'b100);
        run_txn(0);
        run_txn(0);

        // Sweep requester 2 over all words.
        pulse_reset();
        req_data = '0;
        for (int v = 0; v < 8; v++) begin
            drive_word(2, DATA_W'(v));
            req = 4'b0100;
            push_exp(2, DATA_W'(v));
            run_txn(0);
        end
        check("odd_after_sweep", 32'(odd_count), 4);

        // Counter saturation.
        for (int n = 0; n < 258; n++) begin
            drive_word(0, 3'b001);
            req = 4'b0001;
            push_exp(0, 3'b001);
            run_txn(0);
        end
        check("odd_saturated", 32'(odd_count), 255);
        check("sb_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
